// File: rtl/reg_file_pkg.sv
// Shared core constants: datapath widths, named register indices, the
// stack-pointer reset default and the ALU control encodings.
package reg_file_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_AW    = 5;
  localparam int RF_NREGS = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;

  localparam logic [RF_XLEN-1:0] SP_INIT_DEFAULT = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports, the write-back port, the
// debug read port and the committed-write counter.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = RF_AW
);

  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            we;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_data;
  logic [AW-1:0]   dbg_addr;
  logic [XLEN-1:0] dbg_data;
  logic [31:0]     wr_count;

  // core / testbench side
  modport master (
    output rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
    input  rs1_data, rs2_data, dbg_data, wr_count
  );

  // register file side
  modport slave (
    input  rs1_addr, rs2_addr, we, rd_addr, rd_data, dbg_addr,
    output rs1_data, rs2_data, dbg_data, wr_count
  );

endinterface

// File: rtl/reg_file.sv
// RV32I integer register file. x0 has no storage and always reads zero.
// Reads are combinational with no write-to-read bypass: rd_data depends on
// the read data through the ALU, so a bypass would close a combinational loop.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int              XLEN    = RF_XLEN,
  parameter int              NREGS   = RF_NREGS,
  parameter int              AW      = RF_AW,
  parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEFAULT
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [31:0]     wr_count_q;
  logic            wr_en;

  // An unknown rd_addr makes this compare unknown, so no register is touched.
  assign wr_en = bus.we && (bus.rd_addr != AW'(REG_ZERO));

  // Storage and committed-write counter; reset wins over a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
      wr_count_q <= '0;
    end else if (wr_en) begin
      regs_q[bus.rd_addr] <= bus.rd_data;
      wr_count_q          <= wr_count_q + 32'd1;
    end
  end

  assign bus.rs1_data = (bus.rs1_addr == AW'(REG_ZERO)) ? '0 : regs_q[bus.rs1_addr];
  assign bus.rs2_data = (bus.rs2_addr == AW'(REG_ZERO)) ? '0 : regs_q[bus.rs2_addr];
  assign bus.dbg_data = (bus.dbg_addr == AW'(REG_ZERO)) ? '0 : regs_q[bus.dbg_addr];
  assign bus.wr_count = wr_count_q;

  // Simulation-only: flag a write strobe carrying an unknown destination.
  always @(posedge clk) begin
    if (rst_n && bus.we) begin
      a_rd_addr_known: assert (!$isunknown(bus.rd_addr));
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, ALU feedback loop,
// randomized traffic against an array model, async reset and counter wrap.
module tb_reg_file;
  import reg_file_pkg::*;

  localparam logic [31:0] SP = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_loop = 1'b0;
  logic [31:0] rd_drv = '0;

  reg_file_if #(.XLEN(32), .AW(5)) bus ();

  reg_file #(.XLEN(32), .NREGS(32), .AW(5), .SP_INIT(SP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // write-back mux: either a driven value or the ALU sum of both operands
  always_comb bus.rd_data = alu_loop ? (bus.rs1_data + bus.rs2_data) : rd_drv;

  int n_tests = 0;
  int n_fail  = 0;

  // architectural view: 32 registers, x0 pinned at zero, plus a write tally
  logic [31:0] m [32];
  logic [31:0] m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    m[REG_SP] = SP;
    m_cnt = '0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m[a];
  endfunction

  function automatic void model_wr(input logic w, input logic [4:0] a, input logic [31:0] d);
    if (w && a != 5'd0) begin
      m[a] = d;
      m_cnt = m_cnt + 32'd1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1;
    bus.rd_addr = a;
    rd_drv = d;
    @(posedge clk);
    model_wr(1'b1, a, d);
    #1 bus.we = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] b1;
    logic [31:0] b2;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] adbg;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic        w;
    logic [4:0]  ra, r1, r2, rdbg;
    logic [31:0] d, exp_sum;
    logic [31:0] alu_exp [3];

    tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd6,  32'h0,         32'h0,    32'hDEAD_BEEF, 32'h0,    32'hDEAD_BEEF, 32'd1};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h0,         32'h0,    32'h0,         32'h0,    32'h0,         32'd1};
    tbl[2] = '{1'b1, 5'd7,  32'h1,         5'd7,  5'd2,  32'h0,         SP,       32'h1,         SP,       32'h1,         32'd2};
    tbl[3] = '{1'b1, 5'd7,  32'h2,         5'd7,  5'd7,  32'h1,         32'h1,    32'h2,         32'h2,    32'h2,         32'd3};
    tbl[4] = '{1'b0, 5'd5,  32'h1234,      5'd5,  5'd7,  32'hDEAD_BEEF, 32'h2,    32'hDEAD_BEEF, 32'h2,    32'hDEAD_BEEF, 32'd3};
    tbl[5] = '{1'b1, 5'd2,  32'hCAFE,      5'd2,  5'd0,  SP,            32'h0,    32'hCAFE,      32'h0,    32'hCAFE,      32'd4};
    tbl[6] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd30, 32'h0,         32'h0,    32'hA5A5_A5A5, 32'h0,    32'hA5A5_A5A5, 32'd5};
    alu_exp[0] = 32'd7;
    alu_exp[1] = 32'd11;
    alu_exp[2] = 32'd15;

    bus.we = 1'b0; bus.rd_addr = '0; bus.rs1_addr = '0; bus.rs2_addr = '0; bus.dbg_addr = '0;

    // asynchronous reset, observed while still held
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_cnt", bus.wr_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #1 chk($sformatf("rst_dbg_x%0d", i), bus.dbg_data, (i == 2) ? SP : 32'd0);
    end
    bus.rs1_addr = 5'd2; bus.rs2_addr = 5'd0;
    #1 chk("rst_rs1_sp", bus.rs1_data, SP);
    chk("rst_rs2_x0", bus.rs2_data, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    #1 chk("rst_release_sp", bus.rs1_data, SP);

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.we = tbl[i].we; bus.rd_addr = tbl[i].rd; rd_drv = tbl[i].d;
      bus.rs1_addr = tbl[i].r1; bus.rs2_addr = tbl[i].r2;
      #1;
      chk($sformatf("vec%0d_rs1_before", i), bus.rs1_data, tbl[i].b1);
      chk($sformatf("vec%0d_rs2_before", i), bus.rs2_data, tbl[i].b2);
      @(posedge clk);
      model_wr(tbl[i].we, tbl[i].rd, tbl[i].d);
      #1 bus.we = 1'b0; bus.dbg_addr = tbl[i].rd;
      #1;
      chk($sformatf("vec%0d_rs1_after", i), bus.rs1_data, tbl[i].a1);
      chk($sformatf("vec%0d_rs2_after", i), bus.rs2_data, tbl[i].a2);
      chk($sformatf("vec%0d_dbg_after", i), bus.dbg_data, tbl[i].adbg);
      chk($sformatf("vec%0d_cnt", i), bus.wr_count, tbl[i].cnt);
    end

    // ALU feedback: rd_data = rs1_data + rs2_data closes through the file
    write_reg(5'd1, 32'd3);
    write_reg(5'd2, 32'd4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      alu_loop = 1'b1;
      bus.we = 1'b1; bus.rd_addr = 5'd3;
      bus.rs1_addr = (k == 0) ? 5'd1 : 5'd3;
      bus.rs2_addr = 5'd2;
      #1;
      exp_sum = model_rd(bus.rs1_addr) + model_rd(bus.rs2_addr);
      chk($sformatf("alu%0d_sum", k), bus.rd_data, exp_sum);
      @(posedge clk);
      model_wr(1'b1, 5'd3, exp_sum);
      #1 bus.we = 1'b0; bus.dbg_addr = 5'd3;
      #1 chk($sformatf("alu%0d_x3", k), bus.dbg_data, alu_exp[k]);
    end
    alu_loop = 1'b0;
    chk("alu_cnt", bus.wr_count, m_cnt);

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      w = 1'($urandom_range(0, 1));
      ra = 5'($urandom_range(0, 31));
      d = $urandom;
      r1 = 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      rdbg = 5'($urandom_range(0, 31));
      bus.we = w; bus.rd_addr = ra; rd_drv = d;
      bus.rs1_addr = r1; bus.rs2_addr = r2; bus.dbg_addr = rdbg;
      #1;
      chk("rand_rs1", bus.rs1_data, model_rd(r1));
      chk("rand_rs2", bus.rs2_data, model_rd(r2));
      chk("rand_dbg", bus.dbg_data, model_rd(rdbg));
      chk("rand_cnt", bus.wr_count, m_cnt);
      @(posedge clk);
      model_wr(w, ra, d);
    end
    #1 bus.we = 1'b0;

    // fill x1..x31, then reset between edges
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h1000_0000 + 32'(i) * 32'h0001_0101);
    @(negedge clk);
    bus.rs1_addr = 5'd1; bus.rs2_addr = 5'd31; bus.dbg_addr = 5'd2;
    #1 chk("mid_pre_x31", bus.rs2_data, model_rd(5'd31));
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_rs1", bus.rs1_data, 32'd0);
    chk("mid_rst_rs2", bus.rs2_data, 32'd0);
    chk("mid_rst_sp", bus.dbg_data, SP);
    chk("mid_rst_cnt", bus.wr_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #1 chk($sformatf("mid_rst_x%0d", i), bus.dbg_data, model_rd(5'(i)));
    end
    @(negedge clk); #2 rst_n = 1'b1;
    #1 chk("mid_release_cnt", bus.wr_count, 32'd0);

    // reset asserted in the same cycle as a write: write is discarded
    write_reg(5'd9, 32'h99);
    @(negedge clk);
    bus.we = 1'b1; bus.rd_addr = 5'd9; rd_drv = 32'h1234; bus.dbg_addr = 5'd9;
    #3 rst_n = 1'b0;
    @(posedge clk);
    model_reset();
    #1 bus.we = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("rstwr_x9", bus.dbg_data, 32'd0);
    chk("rstwr_cnt", bus.wr_count, 32'd0);

    // counter wrap from all-ones
    write_reg(5'd4, 32'h44);
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFF_FFFF;
    #1 release dut.wr_count_q;
    #1 chk("wrap_preload", bus.wr_count, 32'hFFFF_FFFF);
    m_cnt = 32'hFFFF_FFFF;
    write_reg(5'd5, 32'h55);
    bus.dbg_addr = 5'd5;
    #1;
    chk("wrap_cnt", bus.wr_count, m_cnt);
    chk("wrap_cnt_zero", bus.wr_count, 32'd0);
    chk("wrap_x5", bus.dbg_data, 32'h55);
    write_reg(5'd0, 32'h77);
    #1 chk("wrap_x0_nop_cnt", bus.wr_count, 32'd0);
    write_reg(5'd6, 32'h66);
    #1 chk("wrap_next_cnt", bus.wr_count, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
